// File: rtl/sync_reg_feeder_pkg.sv
// Shared types and constants for the sync_reg_feeder staging stage.
package sync_reg_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 16;
  localparam int LANES_DEFAULT = WIDTH_DEFAULT / 8;

  function automatic int lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/sync_reg_feeder_if.sv
// Producer-write and synchronizer-launch signals of sync_reg_feeder.
interface sync_reg_feeder_if
  import sync_reg_feeder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic               wr_en;
  logic [WIDTH/8-1:0] wr_be;
  logic [WIDTH-1:0]   wr_data;
  logic               sync_en;
  logic [WIDTH-1:0]   sync_d;
  logic               sync_rdy;

  // master: producer plus synchronizer side; slave: the feeder itself
  modport master (
    output wr_en, wr_be, wr_data, sync_rdy,
    input  sync_en, sync_d
  );

  modport slave (
    input  wr_en, wr_be, wr_data, sync_rdy,
    output sync_en, sync_d
  );

endinterface

// File: rtl/sync_reg_feeder_merge.sv
// Byte-enable merge of the shadow register with incoming write data.
module sync_reg_feeder_merge
  import sync_reg_feeder_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int LANES = lanes(WIDTH)
) (
  input  logic [WIDTH-1:0] shadow,
  input  logic [LANES-1:0] be,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] merged
);

  always_comb begin
    // NOTE: default first so every path assigns merged and no latch is inferred.
    merged = shadow;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
  end

endmodule

// File: rtl/sync_reg_feeder.sv
// Coalescing shadow register feeding a handshake register synchronizer.
// Optional write statistics (merge_cnt, overrun) under SYNC_REG_FEEDER_STATS_EN.
module sync_reg_feeder
  import sync_reg_feeder_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CNT_W = CNT_W_DEFAULT
) (
  input  logic             sCLK,
  input  logic             sRST,
  sync_reg_feeder_if.slave bus,
  output logic             pending,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
`ifdef SYNC_REG_FEEDER_STATS_EN
  ,
  output logic [CNT_W-1:0] merge_cnt,
  output logic             overrun
`endif
);

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, merged;
  logic             dirty;
  logic             launch;
  logic             accept;

  assign accept = bus.wr_en & (|bus.wr_be);

  sync_reg_feeder_merge #(.WIDTH(WIDTH)) u_merge (
    .shadow (shadow),
    .be     (bus.wr_be),
    .data   (bus.wr_data),
    .merged (merged)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sCLK) begin
    if (sRST) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    case (state)
      IDLE: begin
        if (dirty && bus.sync_rdy) begin
          launch  = 1'b1;
          state_n = GUARD;
        end
      end
      // One blind cycle while the synchronizer's registered ready falls.
      GUARD:   state_n = WAIT;
      WAIT:    if (bus.sync_rdy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A write in the launch cycle wins over the clear, forcing a follow-up transfer.
  always_ff @(posedge sCLK) begin
    if (sRST) begin
      shadow   <= INIT;
      dirty    <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (accept) shadow <= merged;
      if (accept)      dirty <= 1'b1;
      else if (launch) dirty <= 1'b0;
      if (launch) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  assign bus.sync_en = launch;
  assign bus.sync_d  = shadow;
  assign pending     = dirty;
  assign busy        = (state == GUARD) || (state == WAIT);

`ifdef SYNC_REG_FEEDER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic merge_hit;
  assign merge_hit = accept && (dirty || (busy && !launch));

  always_ff @(posedge sCLK) begin
    if (sRST) begin
      merge_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (merge_hit && (merge_cnt != CNT_MAX)) begin
        merge_cnt <= merge_cnt + CNT_W'(1);
        overrun   <= (merge_cnt == CNT_MAX - CNT_W'(1));
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_reg_feeder.sv
// Directed, table-driven bench for sync_reg_feeder with hand sequences for corner cases.
module tb_sync_reg_feeder;

`ifdef SYNC_REG_FEEDER_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic             sCLK = 1'b0;
  logic             sRST;
  logic             pending;
  logic             busy;
  logic [CNT_W-1:0] xfer_cnt;
`ifdef SYNC_REG_FEEDER_STATS_EN
  logic [CNT_W-1:0] merge_cnt;
  logic             overrun;
`endif

  int passed = 0;
  int total  = 0;

  sync_reg_feeder_if #(.WIDTH(32)) bus ();

  sync_reg_feeder #(.WIDTH(32), .INIT(32'h0), .CNT_W(CNT_W)) dut (
    .sCLK     (sCLK),
    .sRST     (sRST),
    .bus      (bus),
    .pending  (pending),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
`ifdef SYNC_REG_FEEDER_STATS_EN
    ,
    .merge_cnt(merge_cnt),
    .overrun  (overrun)
`endif
  );

  always #5 sCLK = ~sCLK;

  typedef struct {
    logic        rst;
    logic        wr_en;
    logic [3:0]  be;
    logic [31:0] data;
    logic        rdy;
    logic        exp_en;
    logic [31:0] exp_d;
    logic        exp_pend;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic rst, input logic wr_en, input logic [3:0] be,
                       input logic [31:0] data, input logic rdy);
    @(negedge sCLK);
    sRST         = rst;
    bus.wr_en    = wr_en;
    bus.wr_be    = be;
    bus.wr_data  = data;
    bus.sync_rdy = rdy;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic en, input logic [31:0] d,
                            input logic pend, input logic bsy, input logic [15:0] cnt);
    check({tag, ".sync_en"},  32'(bus.sync_en), 32'(en));
    check({tag, ".sync_d"},   bus.sync_d,       d);
    check({tag, ".pending"},  32'(pending),     32'(pend));
    check({tag, ".busy"},     32'(busy),        32'(bsy));
    check({tag, ".xfer_cnt"}, 32'(xfer_cnt),    32'(cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst   wr   be     data           rdy   en    sync_d         pend  busy  cnt
    vecs[0]  = '{1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 16'd1};
    vecs[3]  = '{1'b0, 1'b1, 4'h1, 32'h00000011, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 4'h2, 32'h00002200, 1'b0, 1'b0, 32'hDEADBE11, 1'b1, 1'b1, 16'd1};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b0, 1'b0, 32'hDEAD2211, 1'b1, 1'b1, 16'd1};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b0, 1'b0, 32'hDEAD2211, 1'b1, 1'b1, 16'd1};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b0, 1'b0, 32'hDEAD2211, 1'b1, 1'b1, 16'd1};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 1'b0, 32'hDEAD2211, 1'b1, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 1'b1, 32'hDEAD2211, 1'b1, 1'b0, 16'd1};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 1'b0, 32'hDEAD2211, 1'b0, 1'b1, 16'd2};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 1'b0, 32'hDEAD2211, 1'b0, 1'b1, 16'd2};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 1'b0, 32'hDEAD2211, 1'b0, 1'b0, 16'd2};
    vecs[13] = '{1'b0, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hDEAD2211, 1'b0, 1'b0, 16'd2};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 1'b0, 32'hDEAD2211, 1'b0, 1'b0, 16'd2};

    sRST         = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_be    = 4'h0;
    bus.wr_data  = 32'h0;
    bus.sync_rdy = 1'b1;
    repeat (3) @(posedge sCLK);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
    check_outs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);

    // Launch, merge two byte writes during WAIT, single relaunch, be=0 no-op.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].wr_en, vecs[i].be, vecs[i].data, vecs[i].rdy);
      check_outs($sformatf("v%0d", i), vecs[i].exp_en, vecs[i].exp_d,
                 vecs[i].exp_pend, vecs[i].exp_busy, vecs[i].exp_cnt);
    end

    // Write landing in the launch cycle: old value goes out, new one follows.
    drive(1'b0, 1'b1, 4'hF, 32'h12345678, 1'b1);
    check_outs("lw.pre", 1'b0, 32'hDEAD2211, 1'b0, 1'b0, 16'd2);
    drive(1'b0, 1'b1, 4'hF, 32'hCAFEF00D, 1'b1);
    check_outs("lw.launch", 1'b1, 32'h12345678, 1'b1, 1'b0, 16'd2);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    check_outs("lw.guard", 1'b0, 32'hCAFEF00D, 1'b1, 1'b1, 16'd3);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    check_outs("lw.wait", 1'b0, 32'hCAFEF00D, 1'b1, 1'b1, 16'd3);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    check_outs("lw.relaunch", 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 16'd3);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    check_outs("lw.guard2", 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 16'd4);

    // Reset while waiting with a pending write.
    drive(1'b0, 1'b1, 4'hF, 32'h0BADF00D, 1'b0);
    check_outs("rst.wait", 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 16'd4);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
    check_outs("rst.pend", 1'b0, 32'h0BADF00D, 1'b1, 1'b1, 16'd4);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    check_outs("rst.after", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);

`ifdef SYNC_REG_FEEDER_STATS_EN
    begin
      int ovr_seen;
      ovr_seen = 0;
      check("stats.merge_cnt_reset", 32'(merge_cnt), 32'd0);
      drive(1'b0, 1'b1, 4'hF, 32'h1, 1'b1);
      drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
      check("stats.launch", 32'(bus.sync_en), 32'd1);
      for (int k = 1; k <= 20; k++) begin
        drive(1'b0, 1'b1, 4'hF, 32'(k), 1'b0);
        if (overrun) ovr_seen++;
      end
      drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      if (overrun) ovr_seen++;
      check("stats.merge_cnt_sat", 32'(merge_cnt), 32'd15);
      check("stats.overrun_pulses", 32'(ovr_seen), 32'd1);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sync_reg_feeder.md
Name: sync_reg_feeder

Overview:
- Source-domain staging stage that sits directly upstream of the handshake register synchronizer.
- Absorbs byte-masked register writes from sCLK-domain logic into a shadow register and coalesces bursts of writes.
- Launches one transfer at a time using the synchronizer's enable/ready pair.
- Lets producers write at any rate without waiting the 3 dCLK + 3 sCLK recovery time; the destination always sees the latest merged value.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- INIT, all zeros, reset value of the shadow register; must equal the synchronizer's init value.
- CNT_W, 16, width of the transfer counter and the optional merge counter.

Ports:
- sCLK  in  1  source clock; all logic is on its rising edge.
- sRST  in  1  reset, synchronous, active-high.
- wr_en  in  1  write strobe from producer; always accepted, never back-pressured.
- wr_be  in  WIDTH/8  byte enables for wr_data.
- wr_data  in  WIDTH  write data.
- sync_en  out  1  enable to the synchronizer; one-cycle pulse.
- sync_d  out  WIDTH  data to the synchronizer; equals the shadow register.
- sync_rdy  in  1  ready from the synchronizer.
- pending  out  1  shadow holds data not yet launched.
- busy  out  1  a transfer is in flight (FSM in GUARD or WAIT).
- xfer_cnt  out  CNT_W  number of launched transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: shadow = INIT, dirty = 0, FSM = IDLE, xfer_cnt = 0. This gives sync_en = 0, pending = 0, busy = 0, sync_d = INIT.
- sRST asserted mid-transfer returns everything to reset values on the next edge. Any in-flight handshake is abandoned; the synchronizer is reset by the same system reset.
- Write: if wr_en is high at edge t, each byte i with wr_be[i] = 1 takes wr_data byte i at t+1. Bytes with wr_be = 0 keep their value. dirty is set at t+1 when wr_be is nonzero. wr_en with wr_be = 0 is a no-op.
- sync_d is shadow directly; it is registered and has no combinational path from wr_data.
- sync_en = (state == IDLE) & dirty & sync_rdy. This is combinational from registers plus sync_rdy.
- Launch latency: a write at edge t with the FSM idle and sync_rdy = 1 gives sync_en = 1 during the cycle after t.
- FSM states:
  - IDLE: if sync_en = 1, clear dirty, xfer_cnt += 1, go to GUARD.
  - GUARD: exactly one cycle; sync_rdy is ignored, covering the synchronizer's registered ready drop; go to WAIT.
  - WAIT: stay while sync_rdy = 0; on sync_rdy = 1 go to IDLE. sync_en is never asserted in WAIT; the earliest relaunch is the cycle after returning to IDLE.
- Write in the same cycle as a launch: the launched value is the pre-write shadow. The write lands at the next edge. dirty is set again instead of cleared, so a second transfer follows.
- Writes during GUARD or WAIT merge into the shadow, so only the final merged value is sent after ready returns.
- pending = dirty.
- Destination-visible latency is the synchronizer's own latency plus 1 sCLK.

Optional Feature:
- Macro SYNC_REG_FEEDER_STATS_EN.
- When defined:
  - Adds output merge_cnt [CNT_W].
  - Counts accepted writes (wr_en & |wr_be) that occur while dirty = 1, or while busy = 1 and no launch is happening in that cycle.
  - Saturates at all ones and resets to 0.
  - Adds output overrun, a 1-cycle pulse on the write that makes merge_cnt saturate.
- When undefined: these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the FSM state encoding typedef (IDLE = 2'd0, GUARD = 2'd1, WAIT = 2'd2);
  - the default CNT_W constant;
  - a byte-lane count helper constant (WIDTH/8).
- One sub-module is natural: sync_reg_feeder_merge, the byte-enable merge of shadow and wr_data. It is pure datapath, instantiated once.

Test Plan:
- Reset, then write 0xDEADBEEF with be = 4'hF, sync_rdy held at 1 → sync_en pulses 1 cycle later with sync_d = 0xDEADBEEF, xfer_cnt = 1, busy = 1 for ≥ 2 cycles.
- Model sync_rdy low for 6 cycles after launch. Write 0x11 (be = 4'h1), then 0x2200 (be = 4'h2) during WAIT → a single launch after ready returns, sync_d = 0xDEAD2211, xfer_cnt = 2.
- Write issued in the launch cycle → the first transfer carries the old value and a second transfer follows with the new value; pending = 1 between them.
- sRST asserted during WAIT with pending = 1 → next cycle sync_d = INIT, pending = 0, busy = 0, xfer_cnt = 0, and no sync_en.
- wr_en with be = 0 → no dirty, no sync_en, shadow unchanged.
- With SYNC_REG_FEEDER_STATS_EN defined and CNT_W = 4: 20 writes during WAIT → merge_cnt = 15, overrun pulses exactly once.
